// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch front end.
package cpu_pkg;

   localparam int unsigned DEFAULT_XLEN = 32;
   localparam int unsigned INSTR_BYTES  = 4;

   // Low PC bits that are forced to zero on any fetch address.
   localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_RUN  = 1'b1
   } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// Fetch queue: synchronous FIFO of {instr, pc} entries with a flush that beats push and pop.
module fetch_fifo #(
   parameter  int unsigned WIDTH = 64,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Storage, pointers and occupancy; flush empties the queue without touching storage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem      <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr_q] <= push_data;
            wr_ptr_q      <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   assign count = count_q;
   assign head  = mem[rd_ptr_q];

   // Space is reserved when a request issues, so a push never lands in a full queue.
   assert property (@(posedge clk) disable iff (!rst_n)
                    !(push && !flush && count_q == CW'(DEPTH)));

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, request issue to a 1-cycle imem, and a buffered valid/ready output.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned     XLEN     = DEFAULT_XLEN,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            instr_ready_i
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   fetch_state_e    state_q;
   fetch_state_e    state_d;
   logic [XLEN-1:0] fetch_pc_q;
   logic [XLEN-1:0] req_pc_q;
   logic            inflight_q;
   logic            issue;
   logic            pop;
   logic            push;
   logic [CW-1:0]   q_count;
   logic [OW-1:0]   occupancy;
   logic [2*XLEN-1:0] q_head;

   assign pop  = instr_valid_o & instr_ready_i & ~redirect_valid_i;
   assign push = inflight_q & ~redirect_valid_i;

   // Next state and issue decision; occupancy counts the in-flight slot already reserved.
   always_comb begin
      state_d   = state_q;
      issue     = 1'b0;
      occupancy = OW'(q_count) + OW'(inflight_q) - OW'(pop);
      case (state_q)
         FETCH_IDLE: begin
            if (start_i) state_d = FETCH_RUN;
         end
         FETCH_RUN: begin
            if (!redirect_valid_i && occupancy < OW'(DEPTH)) issue = 1'b1;
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   // State, fetch PC, and tag of the outstanding request.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= FETCH_IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if (redirect_valid_i) begin
            fetch_pc_q <= redirect_pc_i & ~XLEN'(PC_ALIGN_MASK);
         end else if (issue) begin
            fetch_pc_q <= fetch_pc_q + XLEN'(INSTR_BYTES);
            req_pc_q   <= fetch_pc_q;
         end
      end
   end

   assign imem_req_o  = issue;
   assign imem_addr_o = fetch_pc_q;

   fetch_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .push      (push),
      .push_data ({imem_rdata_i, req_pc_q}),
      .pop       (pop),
      .flush     (redirect_valid_i),
      .count     (q_count),
      .head      (q_head)
   );

   assign instr_valid_o           = (q_count != '0);
   assign {instr_o, instr_pc_o}   = q_head;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap and mid-stream reset.
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, redir_v, ready;
   logic [31:0] redir_pc;
   logic        req, valid;
   logic [31:0] addr, rdata, instr, ipc;

   logic        w_start, w_redir_v, w_ready;
   logic [31:0] w_redir_pc;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_rdata, w_instr, w_ipc;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start),
      .redirect_valid_i (redir_v),
      .redirect_pc_i    (redir_pc),
      .imem_req_o       (req),
      .imem_addr_o      (addr),
      .imem_rdata_i     (rdata),
      .instr_valid_o    (valid),
      .instr_o          (instr),
      .instr_pc_o       (ipc),
      .instr_ready_i    (ready)
   );

   fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (w_start),
      .redirect_valid_i (w_redir_v),
      .redirect_pc_i    (w_redir_pc),
      .imem_req_o       (w_req),
      .imem_addr_o      (w_addr),
      .imem_rdata_i     (w_rdata),
      .instr_valid_o    (w_valid),
      .instr_o          (w_instr),
      .instr_pc_o       (w_ipc),
      .instr_ready_i    (w_ready)
   );

   // Memory image: word at byte address a holds 0x1000 + a/4.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000 + (a >> 2);
   endfunction

   // Synchronous instruction memories with one-cycle read latency.
   always @(posedge clk) begin
      rdata   <= req   ? mem_word(addr)   : 32'hDEAD_BEEF;
      w_rdata <= w_req ? mem_word(w_addr) : 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      start   = 1'b0;
      w_start = 1'b0;
      redir_v = 1'b0;
      cyc();
      rst = 1'b1;
   endtask

   // Pulse start in the current cycle and check the cycle-1 request and cycle-3 first output.
   task automatic start_to_first_valid(input logic [31:0] pc0);
      start = 1'b1;
      @(negedge clk);
      check("start_idle_req", 32'(req), 32'd0);
      cyc();
      start = 1'b0;
      @(negedge clk);
      check("first_req", 32'(req), 32'd1);
      check("first_addr", addr, pc0);
      check("c1_valid", 32'(valid), 32'd0);
      cyc();
      @(negedge clk);
      check("c2_valid", 32'(valid), 32'd0);
      cyc();
      @(negedge clk);
      check("c3_valid", 32'(valid), 32'd1);
      check("c3_pc", ipc, pc0);
      check("c3_instr", instr, mem_word(pc0));
   endtask

   initial begin
      int nreq;
      int got;
      logic [31:0] exp_pc;

      ready      = 1'b1;
      redir_pc   = '0;
      w_ready    = 1'b1;
      w_redir_v  = 1'b0;
      w_redir_pc = '0;
      do_reset();

      // Reset state, then start and stream; the wrap instance starts alongside.
      @(negedge clk);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_req", 32'(req), 32'd0);
      check("rst_addr", addr, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_pc", ipc, 32'd0);
      cyc();
      w_start = 1'b1;
      start_to_first_valid(32'h0);
      w_start = 1'b0;
      check("wrap_valid", 32'(w_valid), 32'd1);
      check("wrap_pc", w_ipc, 32'hFFFF_FFF8);
      for (int c = 4; c <= 8; c++) begin
         cyc();
         @(negedge clk);
         check("stream_valid", 32'(valid), 32'd1);
         check("stream_pc", ipc, 32'((c - 3) * 4));
         check("stream_instr", instr, mem_word(32'((c - 3) * 4)));
         if (c <= 6) begin
            check("wrap_pc", w_ipc, 32'hFFFF_FFF8 + 32'((c - 3) * 4));
            check("wrap_instr", w_instr, mem_word(32'hFFFF_FFF8 + 32'((c - 3) * 4)));
         end
      end

      // Reset with two queued entries and a response in flight.
      cyc();
      ready = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", 32'(valid), 32'd1);
      cyc();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      @(negedge clk);
      check("mrst_valid", 32'(valid), 32'd0);
      check("mrst_req", 32'(req), 32'd0);
      check("mrst_addr", addr, 32'd0);
      check("mrst_instr", instr, 32'd0);
      check("mrst_pc", ipc, 32'd0);
      for (int c = 0; c < 3; c++) begin
         cyc();
         @(negedge clk);
         check("idle_req", 32'(req), 32'd0);
         check("idle_valid", 32'(valid), 32'd0);
      end
      cyc();
      ready = 1'b1;
      start_to_first_valid(32'h0);

      // Backpressure from start: four requests fill the queue, head holds at pc 0.
      cyc();
      do_reset();
      ready = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      nreq  = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         nreq += int'(req);
         if (valid) check("bp_head_pc", ipc, 32'h0);
         cyc();
      end
      @(negedge clk);
      check("bp_nreq", 32'(nreq), 32'd4);
      check("bp_req_full", 32'(req), 32'd0);
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_instr", instr, 32'h1000);
      cyc();
      ready  = 1'b1;
      got    = 0;
      exp_pc = 32'h0;
      for (int c = 0; c < 20 && got < 8; c++) begin
         @(negedge clk);
         check("bp_drain_valid", 32'(valid), 32'd1);
         if (valid) begin
            check("bp_drain_pc", ipc, exp_pc);
            exp_pc += 32'd4;
            got++;
         end
         cyc();
      end
      check("bp_drain_count", 32'(got), 32'd8);

      // Redirect to 0x100 while the 0x10 response returns, then a misaligned redirect.
      do_reset();
      start_to_first_valid(32'h0);
      cyc();
      cyc();
      @(negedge clk);
      check("rd_pre_addr", addr, 32'h10);
      check("rd_pre_req", 32'(req), 32'd1);
      cyc();
      redir_v  = 1'b1;
      redir_pc = 32'h100;
      @(negedge clk);
      check("rd_req_cycle", 32'(req), 32'd0);
      cyc();
      redir_v = 1'b0;
      @(negedge clk);
      check("rd_new_req", 32'(req), 32'd1);
      check("rd_new_addr", addr, 32'h100);
      check("rd_n1_valid", 32'(valid), 32'd0);
      cyc();
      @(negedge clk);
      check("rd_n2_valid", 32'(valid), 32'd0);
      cyc();
      @(negedge clk);
      check("rd_valid", 32'(valid), 32'd1);
      check("rd_pc", ipc, 32'h100);
      check("rd_instr", instr, 32'h1040);
      cyc();
      @(negedge clk);
      check("rd_next_pc", ipc, 32'h104);
      cyc();
      redir_v  = 1'b1;
      redir_pc = 32'h103;
      @(negedge clk);
      check("mis_req_cycle", 32'(req), 32'd0);
      cyc();
      redir_v = 1'b0;
      @(negedge clk);
      check("mis_addr", addr, 32'h100);
      check("mis_n1_valid", 32'(valid), 32'd0);
      cyc();
      cyc();
      @(negedge clk);
      check("mis_valid", 32'(valid), 32'd1);
      check("mis_pc", ipc, 32'h100);

      // Redirect while idle moves the PC but does not start fetching.
      cyc();
      do_reset();
      redir_v  = 1'b1;
      redir_pc = 32'h204;
      @(negedge clk);
      check("idle_rd_req", 32'(req), 32'd0);
      cyc();
      redir_v = 1'b0;
      @(negedge clk);
      check("idle_rd_req2", 32'(req), 32'd0);
      check("idle_rd_addr", addr, 32'h204);
      cyc();
      start_to_first_valid(32'h204);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised PC-plus-fetch front end that replaces the bare PC register, PC+4 adder and combinational instruction-memory read in the CPU top.
- Holds the fetch PC and issues requests to a synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions with their PCs in a DEPTH-entry queue and presents them through a valid/ready interface.
- Supports start gating, backpressure and branch/jump redirect with flush.

Parameters:
- XLEN, 32: PC and instruction width in bits.
- DEPTH, 4: fetch-queue entries; must be >= 2.
- RESET_PC, 0: fetch PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- start_i  input  1  begin fetching; sampled only in IDLE.
- redirect_valid_i  input  1  flush the queue and load a new fetch PC.
- redirect_pc_i  input  XLEN  redirect target; bits [1:0] are ignored.
- imem_req_o  output  1  read request this cycle.
- imem_addr_o  output  XLEN  read byte address.
- imem_rdata_i  input  XLEN  read data, valid the cycle after imem_req_o.
- instr_valid_o  output  1  queue head is valid.
- instr_o  output  XLEN  instruction at the queue head.
- instr_pc_o  output  XLEN  PC of the queue head.
- instr_ready_i  input  1  consumer accepts the head this cycle.

Behaviour:
- Reset (rst_i=0 at an edge):
  - State goes to IDLE; fetch_pc loads RESET_PC; queue count, inflight flag and all outputs clear to 0.
  - Any response arriving the cycle after reset is discarded.
  - Reset overrides every other input.
- FSM:
  - IDLE -> RUN on start_i=1. No other transition leaves RUN; only reset returns to IDLE.
  - start_i is ignored in RUN.
- pop = instr_valid_o & instr_ready_i & ~redirect_valid_i.
- Request issue:
  - Condition: RUN & ~redirect_valid_i & (count + inflight - pop < DEPTH).
  - imem_req_o=1 and imem_addr_o=fetch_pc.
  - At the edge: fetch_pc <= fetch_pc + 4, modulo 2^XLEN (wraps to 0), and inflight <= 1.
  - Without an issue, inflight <= 0 and imem_addr_o is held at fetch_pc.
- Response:
  - If inflight=1 and no redirect this cycle, {imem_rdata_i, pc of that request} is pushed at the edge.
  - Space is reserved at issue time, so a push into a full queue cannot occur. This is an assertion target.
- Output:
  - instr_valid_o = (count != 0).
  - instr_o and instr_pc_o are the head entry, registered with no bypass.
  - Head data is stable while instr_valid_o=1 and instr_ready_i=0.
  - Push and pop in the same cycle are both honoured, in FIFO order.
- Latency and throughput:
  - start_i high in cycle 0 gives the first request in cycle 1 and the first instr_valid_o in cycle 3.
  - With instr_ready_i held at 1, one instruction per cycle thereafter.
- Redirect (cycle N, priority over pop and issue):
  - Queue is cleared and the response arriving in cycle N is dropped.
  - fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}.
  - imem_req_o=0 in cycle N.
  - The first request at the new PC is in cycle N+1; no pre-redirect instruction is ever presented after N.
  - Redirect in IDLE updates fetch_pc and stays in IDLE.
- Queue boundaries:
  - At count=DEPTH, no issue unless pop.
  - When empty, instr_valid_o=0 and instr_o/instr_pc_o hold their last value. Benches must not check them.

Decomposition:
- Shared package cpu_pkg: XLEN default, INSTR_BYTES=4, PC alignment mask constant.
- Sub-module fetch_fifo: synchronous FIFO, WIDTH=2*XLEN, parameter DEPTH.
  - Ports: push, pop, flush, count, head data.
  - flush has priority over push and pop.
- fetch_unit holds the FSM, fetch_pc, the inflight flag and the issue logic.

Test Plan:
- Start and stream (RESET_PC=0, mem[i]=0x1000+i, ready=1): start_i pulse in cycle 0 -> first valid in cycle 3 with pc=0, instr=0x1000; then pcs 4, 8, 12... one per cycle, no gaps.
- Backpressure (DEPTH=4, ready=0 from start): after 4 pushes imem_req_o stays 0 and the head stays pc=0. Release ready -> pcs 0,4,8,12,16... with no loss or duplication.
- Redirect with response in flight (redirect_pc_i=0x100 while the 0x10 response returns): next valid pc=0x100; pcs 0x10 and later pre-redirect PCs never appear; imem_req_o=0 in the redirect cycle.
- Misaligned redirect (0x103): next request address 0x100; instr_pc_o=0x100.
- Wrap-around (RESET_PC=0xFFFFFFF8): pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset mid-stream (rst_i=0 for one cycle with queue half full and inflight=1):
  - Next cycle: all outputs 0, state IDLE.
  - No request until start_i.
  - After restart, the first pc is RESET_PC and no stale instruction appears.
